// File: rtl/adders_pkg.sv
// Shared types and defaults for the adders library.
// Holds the serial arithmetic FSM state type and the default operand width.
package adders_pkg;

    localparam int ADDER_WIDTH_DEF = 13;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } serial_state_t;

endpackage

// File: rtl/serial_sub13_if.sv
// Operand/result handshake bundle for serial_sub13.
// Carries the extra op bit when SERIAL_ADDSUB_EN is defined.
interface serial_sub13_if
    import adders_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH_DEF
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;

`ifdef SERIAL_ADDSUB_EN
    logic             op;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, diff, borrow, overflow
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, diff, borrow, overflow
    );
`else
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, overflow
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, overflow
    );
`endif

endinterface

// File: rtl/fa_bit.sv
// Single combinational full-adder cell, the only arithmetic in the serial
// subtractor.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_sub13.sv
// Bit-serial two's-complement subtractor, a - b = a + ~b + 1, LSB first.
// Define SERIAL_ADDSUB_EN to add an op input selecting add (1) or subtract (0).
module serial_sub13
    import adders_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH_DEF
) (
    input logic           clk,
    input logic           reset,
    serial_sub13_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    serial_state_t state;
    serial_state_t next_state;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_sh;
    logic             carry;
    logic             cmsb_in;
    logic [CW-1:0]    cnt;
    logic             s;
    logic             co;
    logic             accept;
    logic             last;
    logic             in_ready_int;
    logic             out_valid_int;
    logic             add_mode;

`ifdef SERIAL_ADDSUB_EN
    logic op_r;
    assign add_mode = op_r;
`else
    assign add_mode = 1'b0;
`endif

    fa_bit u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (s),
        .co (co)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Acceptance is blocked during reset so in_ready reads low while it is held.
    always_comb begin
        next_state    = state;
        in_ready_int  = 1'b0;
        out_valid_int = 1'b0;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                in_ready_int = ~reset;
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid_int = 1'b1;
                if (bus.out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // cmsb_in keeps the carry entering the MSB, taken before the final update.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh    <= '0;
            b_sh    <= '0;
            diff_sh <= '0;
            carry   <= 1'b0;
            cmsb_in <= 1'b0;
            cnt     <= '0;
`ifdef SERIAL_ADDSUB_EN
            op_r    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh <= bus.a;
                        cnt  <= '0;
`ifdef SERIAL_ADDSUB_EN
                        op_r  <= bus.op;
                        b_sh  <= bus.op ? bus.b : ~bus.b;
                        carry <= ~bus.op;
`else
                        b_sh  <= ~bus.b;
                        carry <= 1'b1;
`endif
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    diff_sh <= {s, diff_sh[WIDTH-1:1]};
                    carry   <= co;
                    if (last) begin
                        cmsb_in <= carry;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_int;
    assign bus.diff      = out_valid_int ? diff_sh : '0;
    assign bus.borrow    = out_valid_int & (add_mode ? carry : ~carry);
    assign bus.overflow  = out_valid_int & (cmsb_in ^ carry);

endmodule
